// File: rtl/fir_result_reader.sv
// rtl/fir_result_reader.sv - FIR result stream reader: warm-up skip, FWFT FIFO, sticky overrun flag
// Optional macro FIR_READER_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
module fir_result_reader #(
   parameter int OUT_W = 16,
   parameter int DEPTH = 16,
   parameter int SKIP  = 440
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [OUT_W-1:0]           in,
   input  logic                       valid,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow
`ifdef FIR_READER_DROP_CNT_EN
   ,
   output logic [15:0]                drop_cnt
`endif
);

   localparam int LW  = $clog2(DEPTH+1);
   localparam int PW  = $clog2(DEPTH);
   localparam int SKW = (SKIP < 2) ? 1 : $clog2(SKIP+1);

   typedef enum logic [1:0] {
      ST_SKIP = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   // With no warm-up to discard the reader starts directly in RUN.
   localparam state_t ST_INIT = (SKIP == 0) ? ST_RUN : ST_SKIP;

   state_t           state, state_nxt;
   logic [SKW-1:0]   skip_cnt, skip_cnt_nxt;
   logic [OUT_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             full, pop, push, ovf_evt;

   // Full/empty come from the occupancy counter so pointers can wrap freely.
   assign full      = (level == LW'(DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // Head word falls through; forced to zero while nothing is buffered.
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // State and warm-up counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_cnt_nxt;
      end
   end

   // Next state: count off warm-up pulses, push in RUN, latch into ERR on overrun.
   always_comb begin
      state_nxt    = state;
      skip_cnt_nxt = skip_cnt;
      push         = 1'b0;
      ovf_evt      = 1'b0;
      case (state)
         ST_SKIP: begin
            if (valid) begin
               skip_cnt_nxt = skip_cnt + 1'b1;
               if (skip_cnt_nxt == SKW'(SKIP))
                  state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (valid) begin
               // A pop in the same cycle frees the slot, so a full FIFO still accepts.
               if (!full || pop) begin
                  push = 1'b1;
               end else begin
                  ovf_evt   = 1'b1;
                  state_nxt = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            // Filter pulses are ignored until reset; the FIFO keeps draining.
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   // FIFO storage; contents are not reset, only pointers and level are.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= in;
   end

   // Pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (ovf_evt)
            overflow <= 1'b1;
      end
   end

`ifdef FIR_READER_DROP_CNT_EN
   logic drop_evt;

   // Overrun losses: the overflowing pulse plus every pulse seen while in ERR.
   assign drop_evt = ovf_evt | ((state == ST_ERR) & valid);

   // Saturating count of pulses lost to overrun.
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop_evt && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fir_result_reader.sv
// tb/tb_fir_result_reader.sv - self-checking bench for fir_result_reader (SKIP=4 and SKIP=0 instances)
module tb_fir_result_reader;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] in0, in1, od0, od1;
   logic        v0, v1, r0, r1, ov0, ov1, of0, of1;
   logic [4:0]  lv0, lv1;
`ifdef FIR_READER_DROP_CNT_EN
   logic [15:0] dc0, dc1;
`endif

   int sel;
   int checks   = 0;
   int failures = 0;

   fir_result_reader #(.OUT_W(16), .DEPTH(DEPTH), .SKIP(4)) u_skip (
      .clk(clk), .rst(rst), .in(in0), .valid(v0),
      .out_data(od0), .out_valid(ov0), .out_ready(r0),
      .level(lv0), .overflow(of0)
`ifdef FIR_READER_DROP_CNT_EN
      , .drop_cnt(dc0)
`endif
   );

   fir_result_reader #(.OUT_W(16), .DEPTH(DEPTH), .SKIP(0)) u_noskip (
      .clk(clk), .rst(rst), .in(in1), .valid(v1),
      .out_data(od1), .out_valid(ov1), .out_ready(r1),
      .level(lv1), .overflow(of1)
`ifdef FIR_READER_DROP_CNT_EN
      , .drop_cnt(dc1)
`endif
   );

   logic [15:0] od;
   logic        ov, of;
   logic [4:0]  lv;
   assign od = (sel != 0) ? od1 : od0;
   assign ov = (sel != 0) ? ov1 : ov0;
   assign of = (sel != 0) ? of1 : of0;
   assign lv = (sel != 0) ? lv1 : lv0;
`ifdef FIR_READER_DROP_CNT_EN
   logic [15:0] dc;
   assign dc = (sel != 0) ? dc1 : dc0;
`endif

   // Reference model: queue of buffered words plus behavioural flags.
   logic [15:0] mq[$];
   logic [15:0] got[$];
   int mskip, mcount, mdrop, maxlvl;
   bit merr, movf;

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          r;
      bit          ev;
      logic [15:0] ed;
      logic [4:0]  el;
      bit          eo;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      mcount = 0;
      mdrop  = 0;
      merr   = 1'b0;
      movf   = 1'b0;
   endtask

   task automatic model_update(input bit v, input logic [15:0] d, input bit r);
      int sz;
      bit p;
      sz = mq.size();
      p  = (sz > 0) && r;
      if (p)
         void'(mq.pop_front());
      if (v) begin
         if (mcount < mskip)
            mcount++;
         else if (merr) begin
            if (mdrop < 65535) mdrop++;
         end else if (sz < DEPTH || p)
            mq.push_back(d);
         else begin
            movf = 1'b1;
            merr = 1'b1;
            if (mdrop < 65535) mdrop++;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [15:0] ed;
      ed = (mq.size() > 0) ? mq[0] : 16'h0;
      chk({tag, ".out_valid"}, {31'b0, ov}, (mq.size() > 0) ? 32'd1 : 32'd0);
      chk({tag, ".out_data"}, {16'b0, od}, {16'b0, ed});
      chk({tag, ".level"}, {27'b0, lv}, mq.size());
      chk({tag, ".overflow"}, {31'b0, of}, {31'b0, movf});
`ifdef FIR_READER_DROP_CNT_EN
      chk({tag, ".drop_cnt"}, {16'b0, dc}, mdrop);
`endif
   endtask

   task automatic step(input bit v, input logic [15:0] d, input bit r, input string tag);
      if (sel != 0) begin
         v1 = v; in1 = d; r1 = r; v0 = 1'b0; r0 = 1'b0;
      end else begin
         v0 = v; in0 = d; r0 = r; v1 = 1'b0; r1 = 1'b0;
      end
      if (ov && r)
         got.push_back(od);
      @(posedge clk);
      #1;
      model_update(v, d, r);
      check_model(tag);
      if (int'(lv) > maxlvl)
         maxlvl = int'(lv);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      mskip = (sel != 0) ? 0 : 4;
      model_clear();
      check_model("reset");
      got.delete();
      maxlvl = 0;
   endtask

   initial begin
      rst = 1'b1; in0 = '0; in1 = '0; v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
      sel = 0; mskip = 4; maxlvl = 0;
      model_clear();

      // Latency/hold vectors for the SKIP=0 instance.
      tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 5'd1, 1'b0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 5'd1, 1'b0};
      tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0};
      tbl[7] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0};

      // Warm-up skip: SKIP=4, one pulse every 4 clocks, in=1..10.
      sel = 0;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 16'(i), 1'b1, "warm");
         repeat (3) step(1'b0, 16'h0, 1'b1, "warm");
      end
      repeat (4) step(1'b0, 16'h0, 1'b1, "warm");
      chk("warm.count", got.size(), 32'd6);
      for (int k = 0; k < got.size() && k < 6; k++)
         chk("warm.word", {16'b0, got[k]}, 32'(5 + k));
      chk("warm.maxlevel", maxlvl, 32'd1);

      // Latency and hold, table driven.
      sel = 1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r, "tbl");
         chk("tbl.out_valid", {31'b0, ov}, {31'b0, tbl[i].ev});
         chk("tbl.out_data", {16'b0, od}, {16'b0, tbl[i].ed});
         chk("tbl.level", {27'b0, lv}, {27'b0, tbl[i].el});
         chk("tbl.overflow", {31'b0, of}, {31'b0, tbl[i].eo});
      end

      // Full boundary and overrun into ERR.
      do_reset();
      for (int i = 0; i < 16; i++)
         step(1'b1, 16'(i), 1'b0, "fill");
      chk("full.level", {27'b0, lv}, 32'd16);
      chk("full.overflow", {31'b0, of}, 32'd0);
      step(1'b1, 16'd16, 1'b0, "ovf");
      chk("ovf.overflow", {31'b0, of}, 32'd1);
      chk("ovf.level", {27'b0, lv}, 32'd16);
      repeat (3) step(1'b1, 16'd200, 1'b0, "err");
`ifdef FIR_READER_DROP_CNT_EN
      chk("err.drop_cnt", {16'b0, dc}, 32'd4);
`endif
      got.delete();
      repeat (20) step(1'b0, 16'h0, 1'b1, "drain");
      chk("drain.count", got.size(), 32'd16);
      for (int k = 0; k < got.size() && k < 16; k++)
         chk("drain.word", {16'b0, got[k]}, k);
      chk("drain.overflow", {31'b0, of}, 32'd1);

      // Push and pop together at full.
      do_reset();
      for (int i = 0; i < 16; i++)
         step(1'b1, 16'(100 + i), 1'b0, "fill2");
      got.delete();
      step(1'b1, 16'd99, 1'b1, "pushpop");
      chk("pushpop.level", {27'b0, lv}, 32'd16);
      chk("pushpop.overflow", {31'b0, of}, 32'd0);
      repeat (20) step(1'b0, 16'h0, 1'b1, "drain2");
      chk("pushpop.count", got.size(), 32'd17);
      for (int k = 0; k < got.size() && k < 17; k++)
         chk("pushpop.word", {16'b0, got[k]}, (k < 16) ? 32'(100 + k) : 32'd99);

      // Reset mid-operation on the SKIP=4 instance.
      sel = 0;
      do_reset();
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'(i), 1'b0, "skip");
      chk("skip.level", {27'b0, lv}, 32'd0);
      for (int i = 0; i < 17; i++)
         step(1'b1, 16'(50 + i), 1'b0, "fill3");
      repeat (9) step(1'b0, 16'h0, 1'b1, "part");
      chk("mid.level", {27'b0, lv}, 32'd7);
      chk("mid.overflow", {31'b0, of}, 32'd1);
      do_reset();
      chk("rst.level", {27'b0, lv}, 32'd0);
      chk("rst.out_valid", {31'b0, ov}, 32'd0);
      chk("rst.out_data", {16'b0, od}, 32'd0);
      chk("rst.overflow", {31'b0, of}, 32'd0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'(i), 1'b0, "reskip");
      chk("reskip.level", {27'b0, lv}, 32'd0);
      step(1'b1, 16'd77, 1'b0, "reskip");
      chk("reskip.first_level", {27'b0, lv}, 32'd1);
      chk("reskip.first_data", {16'b0, od}, 32'd77);

      // Randomized traffic against the model on both instances.
      for (int s = 0; s < 2; s++) begin
         sel = s;
         do_reset();
         for (int n = 0; n < 3000; n++) begin
            int ph;
            bit rv, rr;
            ph = (n / 200) % 3;
            rv = ($urandom_range(0, 2) == 0);
            case (ph)
               0:       rr = ($urandom_range(0, 1) == 0);
               1:       rr = 1'b0;
               default: rr = ($urandom_range(0, 9) != 0);
            endcase
            step(rv, 16'($urandom), rr, "rand");
            if (n % 600 == 599)
               do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
